seq_det_ctrl: RTL and testbench

Run controller for the serial pattern detector: holds a programmable pattern, target match count and timeout, and arms and runs a detection session over a qualified serial bit stream. Overlapping matches are counted, and the session ends in DONE, TIMEOUT or abort. It sits between the host/config logic and the serial input, and replaces free-running hard-wired detectors with a sequenced, reportable session.

---
 rtl/seq_det_ctrl.sv | 152 +++++++++++++++
 tb/tb_seq_det_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Run controller for the serial pattern detector: holds pattern/target/timeout
// config and sequences one detection session (IDLE -> SCAN -> DONE/TMO).
module seq_det_ctrl #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TMO_W-1:0] cfg_timeout,
  input  logic             start,
  input  logic             abort,
  input  logic             ip_valid,
  input  logic             ip,
  output logic             busy,
  output logic             seq_det,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             timeout
);

  localparam int unsigned HIST_W = PAT_W - 1;
  localparam int unsigned FILL_W = $clog2(PAT_W);
  localparam logic [PAT_W-1:0] PAT_RST = PAT_W'(1) | (PAT_W'(1) << (PAT_W - 1));
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE, S_TMO} state_t;

  state_t              state_q, state_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [CNT_W-1:0]    tgt_q, tgt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [TMO_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                seq_det_q, seq_det_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                match;
  logic                reached;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pat_q     <= PAT_RST;
      tgt_q     <= CNT_W'(1);
      tmo_q     <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      timer_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      seq_det_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      tgt_q     <= tgt_d;
      tmo_q     <= tmo_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      seq_det_q <= seq_det_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Session sequencing; within SCAN: abort > target-reaching match > timeout.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    tgt_d     = tgt_q;
    tmo_d     = tmo_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    seq_det_d = 1'b0;
    done_d    = done_q;
    timeout_d = timeout_q;
    match     = 1'b0;
    reached   = 1'b0;

    if (cfg_we && state_q != S_SCAN) begin
      pat_d = cfg_pattern;
      tgt_d = cfg_target;
      tmo_d = cfg_timeout;
    end

    case (state_q)
      S_SCAN: begin
        if (abort) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end else begin
          timer_d = timer_q + TMO_W'(1);
          if (ip_valid) begin
            match  = (fill_q == FILL_FULL) && ({hist_q, ip} == pat_q);
            hist_d = HIST_W'({hist_q, ip});
            if (fill_q != FILL_FULL) fill_d = fill_q + FILL_W'(1);
          end
          if (match) begin
            seq_det_d = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            reached = (tgt_q != '0) && (cnt_d == tgt_q);
          end
          if (reached) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (tmo_q != '0 && timer_q == TMO_W'(tmo_q - TMO_W'(1))) begin
            state_d   = S_TMO;
            busy_d    = 1'b0;
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          state_d   = S_SCAN;
          busy_d    = 1'b1;
          hist_d    = '0;
          fill_d    = '0;
          timer_d   = '0;
          cnt_d     = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
    endcase
  end

  assign busy      = busy_q;
  assign seq_det   = seq_det_q;
  assign match_cnt = cnt_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl at default parameters.
module tb_seq_det_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_pattern;
  logic [7:0]  cfg_target;
  logic [15:0] cfg_timeout;
  logic        start;
  logic        abort;
  logic        ip_valid;
  logic        ip;
  logic        busy;
  logic        seq_det;
  logic [7:0]  match_cnt;
  logic        done;
  logic        timeout;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  seq_det_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_target(cfg_target), .cfg_timeout(cfg_timeout), .start(start),
    .abort(abort), .ip_valid(ip_valid), .ip(ip), .busy(busy),
    .seq_det(seq_det), .match_cnt(match_cnt), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    ip_valid = 1'b1;
    ip = b;
    tick();
    ip_valid = 1'b0;
  endtask

  task automatic start_cfg(input logic [3:0] p, input logic [7:0] t, input logic [15:0] to);
    cfg_we = 1'b1; cfg_pattern = p; cfg_target = t; cfg_timeout = to;
    start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
  endtask

  logic [9:0] s2;
  logic [9:0] e2;
  logic [6:0] s3;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_target = '0; cfg_timeout = '0;
    start = 1'b0; abort = 1'b0; ip_valid = 1'b0; ip = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_seq", 32'(seq_det), 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);
    check("rst_done_tmo", 32'({done, timeout}), 32'd0);
    rst = 1'b0;
    tick();

    // defaults: 1001, target 1
    start = 1'b1; tick(); start = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    send(1'b1); send(1'b0); send(1'b0);
    check("t1_nodet", 32'(seq_det), 32'd0);
    send(1'b1);
    check("t1_det", 32'(seq_det), 32'd1);
    check("t1_cnt", 32'(match_cnt), 32'd1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    tick();
    check("t1_pulse1", 32'(seq_det), 32'd0);

    // target 3, overlapping stream 1001001001
    s2 = 10'b1001001001;
    e2 = 10'b0001001001;
    start_cfg(4'b1001, 8'd3, 16'd0);
    for (int i = 9; i >= 0; i--) begin
      send(s2[i]);
      check($sformatf("t2_det%0d", 9 - i), 32'(seq_det), 32'(e2[i]));
    end
    check("t2_cnt", 32'(match_cnt), 32'd3);
    check("t2_done", 32'(done), 32'd1);
    check("t2_tmo", 32'(timeout), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);

    // target 2 with invalid gaps
    s3 = 7'b1001001;
    start_cfg(4'b1001, 8'd2, 16'd0);
    for (int i = 6; i >= 0; i--) begin
      send(s3[i]);
      check($sformatf("t3_det%0d", 6 - i), 32'(seq_det), 32'((i == 3) || (i == 0)));
      if (i != 0) begin
        ip = ~s3[i];
        tick();
        check($sformatf("t3_gap%0d", 6 - i), 32'(seq_det), 32'd0);
      end
    end
    check("t3_cnt", 32'(match_cnt), 32'd2);
    check("t3_done", 32'(done), 32'd1);

    // timeout 20, zero stream
    start_cfg(4'b1001, 8'd5, 16'd20);
    ip_valid = 1'b1; ip = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    check("t4_busy19", 32'(busy), 32'd1);
    check("t4_tmo19", 32'(timeout), 32'd0);
    tick();
    check("t4_tmo20", 32'(timeout), 32'd1);
    check("t4_busy20", 32'(busy), 32'd0);
    check("t4_cnt", 32'(match_cnt), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    ip_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("t4_rearm_tmo", 32'(timeout), 32'd0);
    check("t4_rearm_busy", 32'(busy), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t4_abort_busy", 32'(busy), 32'd0);

    // abort on the target-reaching match
    start_cfg(4'b1001, 8'd2, 16'd0);
    for (int i = 6; i >= 1; i--) send(s3[i]);
    check("t5_cnt1", 32'(match_cnt), 32'd1);
    abort = 1'b1;
    send(s3[0]);
    abort = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_det", 32'(seq_det), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_cnt", 32'(match_cnt), 32'd1);

    // cfg_we ignored during SCAN
    start_cfg(4'b1001, 8'd1, 16'd0);
    cfg_we = 1'b1; cfg_pattern = 4'b1111; tick(); cfg_we = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1);
    check("t5_1111_det", 32'(seq_det), 32'd0);
    check("t5_1111_busy", 32'(busy), 32'd1);
    send(1'b0); send(1'b0); send(1'b1);
    check("t5_keep_det", 32'(seq_det), 32'd1);
    check("t5_keep_done", 32'(done), 32'd1);

    // async reset mid-SCAN
    start_cfg(4'b0110, 8'd3, 16'd0);
    send(1'b0); send(1'b1); send(1'b1); send(1'b0);
    check("t6_cnt_pre", 32'(match_cnt), 32'd1);
    #2;
    rst = 1'b1; start = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_cnt", 32'(match_cnt), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    tick();
    check("t6_start_in_rst", 32'(busy), 32'd0);
    #2;
    rst = 1'b0; start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    send(1'b1); send(1'b0); send(1'b0); send(1'b1);
    check("t6_defpat_det", 32'(seq_det), 32'd1);
    check("t6_defpat_done", 32'(done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
